// File: rtl/operand_issue_pkg.sv
// Shared types for the decode-stage operand issue unit: control word, op classes,
// immediate formats and the op-class to immediate-format mapping.
package operand_issue_pkg;

    typedef logic [63:0] word_t;
    typedef logic [63:0] u64;
    typedef logic [31:0] u32;

    typedef enum logic [3:0] {
        OP_ALU, OP_ALUW, OP_ALUI, OP_ALUIW, OP_LD, OP_SD,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH
    } op_t;

    typedef enum logic [3:0] {
        FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SLL, FN_SRL, FN_SRA,
        FN_SLT, FN_SLTU, FN_MUL, FN_DIV, FN_DIVU, FN_REM, FN_REMU
    } alufunc_t;

    typedef struct packed {
        op_t      op;
        alufunc_t alufunc;
        logic     writes_rd;
        logic     uses_rs1;
        logic     uses_rs2;
    } contral_t;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_t;

    function automatic imm_fmt_t fmt_of(input op_t op);
        case (op)
            OP_SD:            return IMM_S;
            OP_BRANCH:        return IMM_B;
            OP_LUI, OP_AUIPC: return IMM_U;
            OP_JAL:           return IMM_J;
            default:          return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/operand_issue_imm_gen.sv
// Immediate generator: extracts the RV immediate of the requested format from the
// instruction word and sign-extends it to XLEN.
module operand_issue_imm_gen
    import operand_issue_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [31:7]     instr,
    input  imm_fmt_t        fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (fmt)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = {{(XLEN-32){imm32[31]}}, imm32};

endmodule

// File: rtl/operand_issue.sv
// Decode-stage operand fetch/issue: operand/immediate select, per-register pending-write
// scoreboard, RAW stall, writeback bypass and the valid/ready D/E stage register.
module operand_issue
    import operand_issue_pkg::*;
#(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned NREG    = 32,
    parameter int unsigned NWB     = 2,
    parameter int unsigned MAXPEND = 3,
    localparam int unsigned RW     = $clog2(NREG),
    localparam int unsigned CW     = $clog2(MAXPEND + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  contral_t          in_ctl,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [RW-1:0]     in_rs1,
    input  logic [RW-1:0]     in_rs2,
    input  logic [RW-1:0]     in_rd,
    input  logic [XLEN-1:0]   rf_rd1,
    input  logic [XLEN-1:0]   rf_rd2,
    input  logic [NWB-1:0]    wb_valid,
    input  logic [NWB*RW-1:0] wb_rd,
    input  logic [NWB*XLEN-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output contral_t          out_ctl,
    output logic [XLEN-1:0]   out_pc,
    output logic [RW-1:0]     out_rd,
    output logic [XLEN-1:0]   out_op1,
    output logic [XLEN-1:0]   out_op2,
    output logic [XLEN-1:0]   out_imm,
    output logic [31:0]       stall_cnt
);

    localparam logic [CW-1:0] PEND_MAX = CW'(MAXPEND);

    logic [CW-1:0]   pend     [NREG];
    logic [CW-1:0]   pend_nxt [NREG];
    logic [CW:0]     cnt;
    logic            hit1, hit2, chk1, chk2, haz1, haz2, full, hazard;
    logic            stage_writes, load, issue, pend_underflow, wb_dup;
    logic [XLEN-1:0] byp1, byp2, src1, src2, op1, op2, imm;
    logic            unused_opcode;

    assign unused_opcode = ^in_instr[6:0];

    operand_issue_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (in_instr[31:7]),
        .fmt   (fmt_of(in_ctl.op)),
        .imm   (imm)
    );

    // Highest-numbered writeback port wins when several hit the same source.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        byp1 = '0;
        byp2 = '0;
        for (int unsigned i = 0; i < NWB; i++) begin
            if (wb_valid[i] && wb_rd[i*RW +: RW] == in_rs1 && in_rs1 != '0) begin
                hit1 = 1'b1;
                byp1 = wb_data[i*XLEN +: XLEN];
            end
            if (wb_valid[i] && wb_rd[i*RW +: RW] == in_rs2 && in_rs2 != '0) begin
                hit2 = 1'b1;
                byp2 = wb_data[i*XLEN +: XLEN];
            end
        end
        src1 = (in_rs1 == '0) ? '0 : (hit1 ? byp1 : rf_rd1);
        src2 = (in_rs2 == '0) ? '0 : (hit2 ? byp2 : rf_rd2);
    end

    // A writer sitting in the stage register is not yet counted in pend[], so it
    // also counts toward the full check to keep the counter from wrapping.
    always_comb begin
        stage_writes = out_valid && out_ctl.writes_rd;
        chk1 = in_ctl.uses_rs1 && in_rs1 != '0 && !(in_ctl.op inside {OP_AUIPC, OP_JAL});
        chk2 = in_ctl.uses_rs2 && in_rs2 != '0 && !(in_ctl.op inside {OP_AUIPC, OP_JAL});
        haz1 = chk1 && ((pend[in_rs1] != '0 && !(pend[in_rs1] == CW'(1) && hit1))
                        || (stage_writes && out_rd == in_rs1));
        haz2 = chk2 && ((pend[in_rs2] != '0 && !(pend[in_rs2] == CW'(1) && hit2))
                        || (stage_writes && out_rd == in_rs2));
        full = in_ctl.writes_rd && in_rd != '0
               && (pend[in_rd] == PEND_MAX
                   || (pend[in_rd] == PEND_MAX - CW'(1) && stage_writes && out_rd == in_rd));
        hazard   = haz1 || haz2 || full;
        in_ready = !hazard && (!out_valid || out_ready) && !flush;
        load     = in_valid && in_ready;
        issue    = out_valid && out_ready && !flush;
    end

    always_comb begin
        op1 = src1;
        op2 = src2;
        case (in_ctl.op)
            OP_ALUW: begin
                if (in_ctl.alufunc inside {FN_DIV, FN_REM}) begin
                    op1 = {{(XLEN-32){src1[31]}}, src1[31:0]};
                    op2 = {{(XLEN-32){src2[31]}}, src2[31:0]};
                end else if (in_ctl.alufunc inside {FN_DIVU, FN_REMU}) begin
                    op1 = {{(XLEN-32){1'b0}}, src1[31:0]};
                    op2 = {{(XLEN-32){1'b0}}, src2[31:0]};
                end
            end
            OP_ALUI, OP_ALUIW, OP_LD, OP_SD, OP_LUI: op2 = imm;
            OP_AUIPC: begin
                op1 = in_pc;
                op2 = imm;
            end
            OP_JAL, OP_JALR: begin
                op1 = in_pc;
                op2 = XLEN'(4);
            end
            default: ;
        endcase
    end

    always_comb begin
        pend_underflow = 1'b0;
        wb_dup         = 1'b0;
        cnt            = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            cnt = {1'b0, pend[r]};
            if (r != 0 && issue && out_ctl.writes_rd && out_rd == RW'(r))
                cnt = cnt + (CW+1)'(1);
            for (int unsigned i = 0; i < NWB; i++) begin
                if (r != 0 && wb_valid[i] && wb_rd[i*RW +: RW] == RW'(r)) begin
                    if (cnt == '0) pend_underflow = 1'b1;
                    else           cnt = cnt - (CW+1)'(1);
                end
            end
            pend_nxt[r] = cnt[CW-1:0];
        end
        for (int unsigned i = 0; i < NWB; i++)
            for (int unsigned j = i + 1; j < NWB; j++)
                if (wb_valid[i] && wb_valid[j] && wb_rd[i*RW +: RW] == wb_rd[j*RW +: RW]
                    && wb_rd[i*RW +: RW] != '0)
                    wb_dup = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREG; r++) pend[r] <= '0;
            stall_cnt <= '0;
        end else begin
            pend <= pend_nxt;
            if (in_valid && hazard && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_ctl   <= '0;
            out_pc    <= '0;
            out_rd    <= '0;
            out_op1   <= '0;
            out_op2   <= '0;
            out_imm   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_ctl   <= in_ctl;
            out_pc    <= in_pc;
            out_rd    <= in_rd;
            out_op1   <= op1;
            out_op2   <= op2;
            out_imm   <= imm;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (reset) !pend_underflow);
    a_no_wb_dup:    assert property (@(posedge clk) disable iff (reset) !wb_dup);

endmodule
